// File: rtl/sha256_block_sequencer_pkg.sv
// Shared types and constants for the SHA-256 block sequencer: round constants,
// initial hash value, FSM states and the per-word chaining adder.
package sha256_block_sequencer_pkg;

   typedef logic [31:0]      word_t;
   typedef logic [0:7][31:0] hash_t;   // element 0 = H0 = most significant word

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_RUN,
      ST_CAPTURE,
      ST_ACCUM,
      ST_OUT
   } state_t;

   localparam int unsigned CAPTURE_DLY_DEF = 4;
   localparam int unsigned TIMEOUT_CYC_DEF = 100;

   localparam hash_t IV = {
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   localparam word_t K_TAB [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   function automatic hash_t hash_add(input hash_t a, input hash_t b);
      hash_t r;
      for (int unsigned i = 0; i < 8; i++) begin
         r[i] = a[i] + b[i];
      end
      return r;
   endfunction

endpackage

// File: rtl/sha256_block_sequencer_if.sv
// Block/digest streams plus the core-side control bus of the sequencer.
// slave = sequencer view; master = host and compression core view.
interface sha256_block_sequencer_if;

   logic         in_valid;
   logic         in_ready;
   logic [511:0] in_block;
   logic         in_last;
   logic         out_valid;
   logic         out_ready;
   logic [255:0] out_digest;
   logic         busy;
   logic         err_timeout;
   logic         core_start;
   logic [511:0] core_block;
   logic [255:0] core_iv;
   logic [5:0]   core_t;
   logic [31:0]  core_k;
   logic         core_done;
   logic [255:0] core_hash;

   modport slave (
      input  in_valid, in_block, in_last, out_ready, core_t, core_done, core_hash,
      output in_ready, out_valid, out_digest, busy, err_timeout,
             core_start, core_block, core_iv, core_k
   );

   modport master (
      output in_valid, in_block, in_last, out_ready, core_t, core_done, core_hash,
      input  in_ready, out_valid, out_digest, busy, err_timeout,
             core_start, core_block, core_iv, core_k
   );

endinterface

// File: rtl/sha256_block_sequencer_k_rom.sv
// SHA-256 round constant ROM: combinational K[t] lookup.
module sha256_block_sequencer_k_rom
   import sha256_block_sequencer_pkg::*;
(
   input  logic [5:0] i_addr,
   output word_t      o_k
);

   always_comb begin
      o_k = K_TAB[i_addr];
   end

endmodule

// File: rtl/sha256_block_sequencer.sv
// Drives one compression-core run per padded block, chains H(i) = H(i-1) + core
// result, and presents the final digest with valid/ready backpressure.
module sha256_block_sequencer
   import sha256_block_sequencer_pkg::*;
#(
   parameter int unsigned CAPTURE_DLY = CAPTURE_DLY_DEF,
   parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic                     clk,
   input  logic                     reset,
   sha256_block_sequencer_if.slave  bus
);

   localparam int unsigned CAP_W    = (CAPTURE_DLY < 1) ? 1 : $clog2(CAPTURE_DLY + 1);
   localparam logic [CAP_W-1:0] CAP_LAST = CAP_W'(CAPTURE_DLY);
   localparam logic [6:0]       RUN_LAST = 7'(TIMEOUT_CYC - 1);

   state_t           r_state;
   logic             r_in_ready;
   logic             r_out_valid;
   logic [255:0]     r_digest;
   logic             r_busy;
   logic             r_err;
   logic             r_start;
   logic [511:0]     r_block;
   logic             r_last;
   hash_t            r_chain;
   hash_t            r_hash;
   logic [6:0]       r_run_cnt;
   logic [CAP_W-1:0] r_cap_cnt;
   hash_t            w_sum;
   word_t            w_k;

   sha256_block_sequencer_k_rom u_k_rom (
      .i_addr (bus.core_t),
      .o_k    (w_k)
   );

   assign w_sum = hash_add(r_chain, r_hash);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= ST_IDLE;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_digest    <= '0;
         r_busy      <= 1'b0;
         r_err       <= 1'b0;
         r_start     <= 1'b0;
         r_block     <= '0;
         r_last      <= 1'b0;
         r_chain     <= IV;
         r_hash      <= '0;
         r_run_cnt   <= '0;
         r_cap_cnt   <= '0;
      end else begin
         r_start <= 1'b0;
         unique case (r_state)
            ST_IDLE: begin
               if (bus.in_valid && r_in_ready) begin
                  r_block    <= bus.in_block;
                  r_last     <= bus.in_last;
                  r_err      <= 1'b0;
                  r_start    <= 1'b1;
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b1;
                  r_state    <= ST_START;
               end
            end
            ST_START: begin
               r_run_cnt <= '0;
               r_state   <= ST_RUN;
            end
            ST_RUN: begin
               if (bus.core_done) begin
                  r_cap_cnt <= '0;
                  r_state   <= ST_CAPTURE;
               end else if (r_run_cnt == RUN_LAST) begin
                  // abandon the whole message: next block starts from IV
                  r_err      <= 1'b1;
                  r_chain    <= IV;
                  r_in_ready <= 1'b1;
                  r_busy     <= 1'b0;
                  r_state    <= ST_IDLE;
               end else begin
                  r_run_cnt <= r_run_cnt + 7'd1;
               end
            end
            ST_CAPTURE: begin
               if (r_cap_cnt == CAP_LAST) begin
                  r_hash  <= bus.core_hash;
                  r_state <= ST_ACCUM;
               end else begin
                  r_cap_cnt <= r_cap_cnt + 1'b1;
               end
            end
            ST_ACCUM: begin
               if (r_last) begin
                  r_digest    <= w_sum;
                  r_chain     <= IV;
                  r_out_valid <= 1'b1;
                  r_state     <= ST_OUT;
               end else begin
                  r_chain    <= w_sum;
                  r_in_ready <= 1'b1;
                  r_busy     <= 1'b0;
                  r_state    <= ST_IDLE;
               end
            end
            ST_OUT: begin
               if (bus.out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_busy      <= 1'b0;
                  r_state     <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.in_ready    = r_in_ready;
   assign bus.out_valid   = r_out_valid;
   assign bus.out_digest  = r_digest;
   assign bus.busy        = r_busy;
   assign bus.err_timeout = r_err;
   assign bus.core_start  = r_start;
   assign bus.core_block  = r_block;
   assign bus.core_iv     = r_chain;
   assign bus.core_k      = w_k;

endmodule

// File: tb/tb_sha256_block_sequencer.sv
// Directed bench: behavioural SHA-256 core (64 rounds, K fetched from the DUT,
// staggered result words) plus host stimulus with known NIST digests.
module tb_sha256_block_sequencer;

   localparam logic [255:0] TB_IV = {
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };
   localparam logic [511:0] BLK_ABC = {32'h61626380, {14{32'h0}}, 32'h00000018};
   localparam logic [511:0] BLK_AZ  = {32'h61626364, 32'h65666768, 32'h696a6b6c, 32'h6d6e6f70,
                                       32'h71727374, 32'h75767778, 32'h797a8000, {8{32'h0}},
                                       32'h000000d0};
   localparam logic [511:0] BLK_2A  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                       32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                       32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                       32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
   localparam logic [511:0] BLK_2B  = {{15{32'h0}}, 32'h000001c0};
   localparam logic [255:0] DIG_ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
   localparam logic [255:0] DIG_AZ  = 256'h71c480df93d6ae2f1efad1447c66c9525e316218cf51fc8d9ed832f2daf18b73;
   localparam logic [255:0] DIG_2   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

   logic clk;
   logic reset;
   int unsigned n_checks;
   int unsigned n_fail;

   sha256_block_sequencer_if bus ();

   sha256_block_sequencer #(
      .CAPTURE_DLY (4),
      .TIMEOUT_CYC (100)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // ---------------- behavioural compression core ----------------
   logic [31:0]      cm_w [64];
   logic [31:0]      ca, cb, cc, cd, ce, cf, cg, ch;
   logic [31:0]      t1, t2;
   logic [0:7][31:0] cm_res;
   logic [0:7][31:0] cm_out;
   int               cm_t;
   int               cm_since;
   bit               cm_run;
   bit               cm_hang;
   int unsigned      cm_starts;

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   always @(negedge clk or negedge reset) begin
      if (!reset) begin
         cm_run        = 1'b0;
         cm_since      = 0;
         cm_t          = 0;
         bus.core_done = 1'b0;
         bus.core_t    = '0;
         bus.core_hash = '0;
      end else begin
         if (bus.core_start) begin
            cm_starts++;
            for (int i = 0; i < 16; i++) cm_w[i] = bus.core_block[511 - 32*i -: 32];
            for (int i = 16; i < 64; i++)
               cm_w[i] = cm_w[i-16] + cm_w[i-7]
                       + (rotr(cm_w[i-15], 7) ^ rotr(cm_w[i-15], 18) ^ (cm_w[i-15] >> 3))
                       + (rotr(cm_w[i-2], 17) ^ rotr(cm_w[i-2], 19) ^ (cm_w[i-2] >> 10));
            {ca, cb, cc, cd, ce, cf, cg, ch} = bus.core_iv;
            cm_t          = 0;
            cm_run        = 1'b1;
            bus.core_done = 1'b0;
            bus.core_t    = '0;
         end else if (cm_run && !cm_hang) begin
            t1 = ch + (rotr(ce, 6) ^ rotr(ce, 11) ^ rotr(ce, 25)) + ((ce & cf) ^ (~ce & cg))
               + bus.core_k + cm_w[cm_t];
            t2 = (rotr(ca, 2) ^ rotr(ca, 13) ^ rotr(ca, 22)) + ((ca & cb) ^ (ca & cc) ^ (cb & cc));
            ch = cg; cg = cf; cf = ce; ce = cd + t1;
            cd = cc; cc = cb; cb = ca; ca = t1 + t2;
            if (cm_t == 63) begin
               cm_run        = 1'b0;
               cm_since      = 0;
               cm_res        = {ca, cb, cc, cd, ce, cf, cg, ch};
               bus.core_done = 1'b1;
            end else begin
               cm_t++;
               bus.core_t = 6'(cm_t);
            end
         end else if (bus.core_done && cm_since < 15) begin
            cm_since++;
         end
         // word j settles j/2 cycles after done; before that it reads as garbage
         for (int j = 0; j < 8; j++)
            cm_out[j] = (bus.core_done && cm_since >= j/2) ? cm_res[j] : ~cm_res[j];
         bus.core_hash = cm_out;
      end
   end

   // ---------------- host side ----------------
   task automatic send(input logic [511:0] blk, input logic last);
      int unsigned n = 0;
      while (!bus.in_ready && n < 500) begin
         @(posedge clk); #1;
         n++;
      end
      chk("accept_ready", bus.in_ready, 1);
      bus.in_block = blk;
      bus.in_last  = last;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_out(output int unsigned n);
      n = 0;
      while (!bus.out_valid && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      chk("out_valid_seen", bus.out_valid, 1);
   endtask

   task automatic take_digest(input string tag, input logic [255:0] exp);
      chk(tag, bus.out_digest, exp);
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      chk("post_hs_out_valid", bus.out_valid, 0);
      chk("post_hs_in_ready", bus.in_ready, 1);
   endtask

   task automatic reset_vals(input string tag);
      chk({tag, "_in_ready"}, bus.in_ready, 1);
      chk({tag, "_out_valid"}, bus.out_valid, 0);
      chk({tag, "_out_digest"}, bus.out_digest, 0);
      chk({tag, "_busy"}, bus.busy, 0);
      chk({tag, "_err"}, bus.err_timeout, 0);
      chk({tag, "_core_start"}, bus.core_start, 0);
      chk({tag, "_core_block"}, bus.core_block, 0);
      chk({tag, "_core_iv"}, bus.core_iv, TB_IV);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned      n;
      int unsigned      s0;
      bit               seen_ov;
      logic [255:0]     held;
      logic [0:7][31:0] chain1;
      n_checks = 0;
      n_fail   = 0;
      cm_hang  = 1'b0;
      cm_starts = 0;
      reset = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_block  = '0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset_vals("rst");
      reset = 1'b1;
      @(posedge clk); #1;

      // "abc": start pulse, latency, digest
      s0 = cm_starts;
      send(BLK_ABC, 1'b1);
      chk("abc_core_start", bus.core_start, 1);
      chk("abc_core_block", bus.core_block, BLK_ABC);
      chk("abc_busy", bus.busy, 1);
      chk("abc_in_ready", bus.in_ready, 0);
      chk("abc_core_iv", bus.core_iv, TB_IV);
      @(posedge clk); #1;
      chk("abc_start_pulse", bus.core_start, 0);
      wait_out(n);
      chk("abc_latency", 32'(n + 1), 32'd71);
      chk("abc_one_start", 32'(cm_starts - s0), 32'd1);
      take_digest("abc_digest", DIG_ABC);
      chk("abc_idle_busy", bus.busy, 0);

      // a..z with 10 cycles of backpressure and a refused block
      send(BLK_AZ, 1'b1);
      wait_out(n);
      held = bus.out_digest;
      s0 = cm_starts;
      bus.in_block = BLK_ABC;
      bus.in_last  = 1'b1;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         chk("bp_out_valid", bus.out_valid, 1);
         chk("bp_digest_stable", bus.out_digest, held);
         chk("bp_in_ready", bus.in_ready, 0);
      end
      bus.in_valid = 1'b0;
      chk("bp_no_start", 32'(cm_starts - s0), 32'd0);
      take_digest("az_digest", DIG_AZ);

      // two-block message: no digest after block 1, chaining into block 2
      send(BLK_2A, 1'b0);
      seen_ov = 1'b0;
      n = 0;
      while (!bus.in_ready && n < 300) begin
         @(posedge clk); #1;
         if (bus.out_valid) seen_ov = 1'b1;
         n++;
      end
      chk("blk1_no_out_valid", seen_ov, 0);
      for (int i = 0; i < 8; i++) chain1[i] = TB_IV[255 - 32*i -: 32] + cm_res[i];
      send(BLK_2B, 1'b1);
      chk("blk2_core_iv", bus.core_iv, chain1);
      wait_out(n);
      take_digest("two_block_digest", DIG_2);

      // timeout on block 2 of a message, then recovery with "abc"
      send(BLK_2A, 1'b0);
      n = 0;
      while (!bus.in_ready && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      cm_hang = 1'b1;
      send(BLK_2B, 1'b1);
      n = 0;
      while (!bus.err_timeout && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      chk("to_err", bus.err_timeout, 1);
      chk("to_cycles", 32'(n), 32'd101);
      chk("to_in_ready", bus.in_ready, 1);
      chk("to_busy", bus.busy, 0);
      chk("to_chain_iv", bus.core_iv, TB_IV);
      cm_hang = 1'b0;
      @(posedge clk); #1;
      chk("to_err_sticky", bus.err_timeout, 1);
      send(BLK_ABC, 1'b1);
      chk("to_err_cleared", bus.err_timeout, 0);
      wait_out(n);
      take_digest("to_abc_digest", DIG_ABC);

      // asynchronous reset during RUN of block 1 of 2
      send(BLK_2A, 1'b0);
      repeat (20) @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      reset_vals("midrst");
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      send(BLK_ABC, 1'b1);
      chk("midrst_core_iv", bus.core_iv, TB_IV);
      wait_out(n);
      take_digest("midrst_abc_digest", DIG_ABC);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
